div: RTL and testbench

- Multi-cycle 32-bit integer divider in the EX stage. Serves the MIPS DIV/DIVU instructions.
- This block is a stall requester, not a stall controller. It raises `stallreq_o` while a division is in flight; EX forwards it as the EX stall request to the pipeline controller.
- Method: restoring shift-subtract, one quotient bit per cycle.
- Result format: remainder in the upper word and quotient in the lower word, ready for the HI/LO write.

---
 rtl/div_pkg.sv | 31 +++
 rtl/div_if.sv | 30 +++
 rtl/div_step.sv | 24 ++
 rtl/div.sv | 130 +++++++++++++
 tb/tb_div.sv | 219 +++++++++++++++++++++
 5 files changed

// File: rtl/div_pkg.sv
`default_nettype none
// ============================================================================
// Module      : div_pkg
// Description : Shared widths, divider state encodings and handshake values.
// Revision    : 1.0 - initial release
// ============================================================================
package div_pkg;

    localparam int RegBus       = 32;
    localparam int DoubleRegBus = 64;

    typedef enum logic [1:0] {
        DivFree   = 2'b00,
        DivByZero = 2'b01,
        DivOn     = 2'b10,
        DivEnd    = 2'b11
    } div_state_e;

    localparam logic DivResultReady    = 1'b1;
    localparam logic DivResultNotReady = 1'b0;
    localparam logic DivStart          = 1'b1;
    localparam logic DivStop           = 1'b0;

    // Two's-complement negate when en is set; otherwise pass through.
    function automatic logic [RegBus-1:0] negate_if(input logic [RegBus-1:0] v,
                                                    input logic              en);
        return en ? (~v + RegBus'(1)) : v;
    endfunction

endpackage
`default_nettype wire

// File: rtl/div_if.sv
`default_nettype none
// ============================================================================
// Module      : div_if
// Description : EX-stage to divider request/response bundle.
// Revision    : 1.0 - initial release
// ============================================================================
interface div_if;
    import div_pkg::*;

    logic                    signed_div_i;
    logic [RegBus-1:0]       opdata1_i;
    logic [RegBus-1:0]       opdata2_i;
    logic                    start_i;
    logic                    annul_i;
    logic [DoubleRegBus-1:0] result_o;
    logic                    ready_o;
    logic                    stallreq_o;

    modport master (
        output signed_div_i, opdata1_i, opdata2_i, start_i, annul_i,
        input  result_o, ready_o, stallreq_o
    );

    modport slave (
        input  signed_div_i, opdata1_i, opdata2_i, start_i, annul_i,
        output result_o, ready_o, stallreq_o
    );

endinterface
`default_nettype wire

// File: rtl/div_step.sv
`default_nettype none
// ============================================================================
// Module      : div_step
// Description : One restoring shift-subtract iteration on the working register.
// Revision    : 1.0 - initial release
// ============================================================================
module div_step
    import div_pkg::*;
(
    input  logic [2*RegBus-1:0] working_i,
    input  logic [RegBus-1:0]   divisor_i,
    output logic [2*RegBus:0]   working_o
);

    logic [RegBus:0] w_diff;

    assign w_diff = {1'b0, working_i[2*RegBus-1:RegBus]} - {1'b0, divisor_i};

    // Borrow out means the partial remainder is smaller than the divisor.
    assign working_o = w_diff[RegBus] ? {working_i, 1'b0}
                                      : {w_diff[RegBus-1:0], working_i[RegBus-1:0], 1'b1};

endmodule
`default_nettype wire

// File: rtl/div.sv
`default_nettype none
// ============================================================================
// Module      : div
// Description : Multi-cycle 32-bit signed/unsigned restoring divider (EX stage).
// Revision    : 1.0 - initial release
// ============================================================================
module div
    import div_pkg::*;
(
    input  logic clk,
    input  logic rst,
    div_if.slave bus
);

    div_state_e              state_q, state_d;
    logic [5:0]              cnt_q, cnt_d;
    logic [2*RegBus:0]       working_q, working_d;
    logic [RegBus-1:0]       divisor_q, divisor_d;
    logic                    neg_quot_q, neg_quot_d;
    logic                    neg_rem_q, neg_rem_d;
    logic                    ready_q, ready_d;
    logic [DoubleRegBus-1:0] result_q, result_d;

    logic [2*RegBus:0]       step_next;
    logic [RegBus-1:0]       quot_raw;
    logic [RegBus-1:0]       rem_raw;

    div_step u_step (
        .working_i (working_q[2*RegBus-1:0]),
        .divisor_i (divisor_q),
        .working_o (step_next)
    );

    assign quot_raw = working_q[RegBus-1:0];
    assign rem_raw  = working_q[2*RegBus:RegBus+1];

    assign bus.result_o   = result_q;
    assign bus.ready_o    = ready_q;
    assign bus.stallreq_o = bus.start_i & ~ready_q & ~bus.annul_i;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q    <= DivFree;
            cnt_q      <= '0;
            working_q  <= '0;
            divisor_q  <= '0;
            neg_quot_q <= 1'b0;
            neg_rem_q  <= 1'b0;
            ready_q    <= DivResultNotReady;
            result_q   <= '0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            working_q  <= working_d;
            divisor_q  <= divisor_d;
            neg_quot_q <= neg_quot_d;
            neg_rem_q  <= neg_rem_d;
            ready_q    <= ready_d;
            result_q   <= result_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        working_d  = working_q;
        divisor_d  = divisor_q;
        neg_quot_d = neg_quot_q;
        neg_rem_d  = neg_rem_q;
        ready_d    = ready_q;
        result_d   = result_q;

        case (state_q)
            DivFree: begin
                ready_d  = DivResultNotReady;
                result_d = '0;
                if (bus.start_i == DivStart && !bus.annul_i) begin
                    if (bus.opdata2_i == '0) begin
                        state_d = DivByZero;
                    end else begin
                        state_d    = DivOn;
                        cnt_d      = '0;
                        divisor_d  = negate_if(bus.opdata2_i, bus.signed_div_i & bus.opdata2_i[RegBus-1]);
                        working_d  = {{RegBus{1'b0}},
                                      negate_if(bus.opdata1_i, bus.signed_div_i & bus.opdata1_i[RegBus-1]),
                                      1'b0};
                        neg_quot_d = bus.signed_div_i & (bus.opdata1_i[RegBus-1] ^ bus.opdata2_i[RegBus-1]);
                        neg_rem_d  = bus.signed_div_i & bus.opdata1_i[RegBus-1];
                    end
                end
            end
            DivByZero, DivOn: begin
                if (bus.annul_i) begin
                    state_d    = DivFree;
                    cnt_d      = '0;
                    working_d  = '0;
                    divisor_d  = '0;
                    neg_quot_d = 1'b0;
                    neg_rem_d  = 1'b0;
                    ready_d    = DivResultNotReady;
                    result_d   = '0;
                end else if (state_q == DivByZero) begin
                    working_d = '0;
                    state_d   = DivEnd;
                end else if (cnt_q != 6'd32) begin
                    working_d = step_next;
                    cnt_d     = cnt_q + 6'd1;
                end else begin
                    result_d = {negate_if(rem_raw, neg_rem_q), negate_if(quot_raw, neg_quot_q)};
                    ready_d  = DivResultReady;
                    cnt_d    = '0;
                    state_d  = DivEnd;
                end
            end
            DivEnd: begin
                // Result was latched on entry (zero for the divide-by-zero path).
                if (bus.start_i == DivStop) begin
                    state_d  = DivFree;
                    ready_d  = DivResultNotReady;
                    result_d = '0;
                end else begin
                    ready_d = DivResultReady;
                end
            end
            default: state_d = DivFree;
        endcase
    end

endmodule
`default_nettype wire

// File: tb/tb_div.sv
`default_nettype none
// ============================================================================
// Module      : tb_div
// Description : Self-checking bench for div against an arithmetic reference.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_div;

    logic clk;
    logic rst_n;
    int   checks;
    int   failures;

    div_if bus ();

    div dut (
        .clk (clk),
        .rst (rst_n),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Plain integer arithmetic: truncating division, remainder takes dividend sign.
    function automatic logic [63:0] ref_div(input logic s, input logic [31:0] a,
                                            input logic [31:0] b);
        longint sa, sb, q, r;
        if (b == 32'd0) return 64'd0;
        if (s) begin
            sa = longint'($signed(a));
            sb = longint'($signed(b));
        end else begin
            sa = longint'({32'd0, a});
            sb = longint'({32'd0, b});
        end
        q = sa / sb;
        r = sa % sb;
        return {r[31:0], q[31:0]};
    endfunction

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Issue one division, measure latency and stall width, hold start for
    // 'hold' extra cycles, then drop start and confirm the outputs clear.
    task automatic run_div(input logic s, input logic [31:0] a, input logic [31:0] b,
                           input string tag, input int hold);
        logic [63:0] exp;
        int          exp_lat;
        int          edges;
        int          stalls;
        bit          done;
        exp     = ref_div(s, a, b);
        exp_lat = (b == 32'd0) ? 2 : 33;
        bus.signed_div_i = s;
        bus.opdata1_i    = a;
        bus.opdata2_i    = b;
        bus.annul_i      = 1'b0;
        bus.start_i      = 1'b1;
        edges  = 0;
        stalls = 0;
        done   = 1'b0;
        while (!done) begin
            @(posedge clk);
            edges++;
            #1;
            if (bus.ready_o) done = 1'b1;
            else begin
                if (bus.stallreq_o) stalls++;
                if (edges > 60) done = 1'b1;
            end
        end
        chk({tag, "_latency"}, 64'(edges - 1), 64'(exp_lat));
        chk({tag, "_stall"},   64'(stalls),    64'(exp_lat));
        chk({tag, "_result"},  bus.result_o,   exp);
        for (int i = 0; i < hold; i++) begin
            @(posedge clk);
            #1;
            chk({tag, "_hold_ready"},  64'(bus.ready_o), 64'd1);
            chk({tag, "_hold_result"}, bus.result_o,     exp);
        end
        bus.start_i = 1'b0;
        @(posedge clk);
        #1;
        chk({tag, "_drop_ready"},  64'(bus.ready_o), 64'd0);
        chk({tag, "_drop_result"}, bus.result_o,     64'd0);
    endtask

    initial begin
        logic        s;
        logic [31:0] a, b;
        int          sel;
        checks   = 0;
        failures = 0;
        rst_n            = 1'b0;
        bus.signed_div_i = 1'b0;
        bus.opdata1_i    = '0;
        bus.opdata2_i    = '0;
        bus.start_i      = 1'b0;
        bus.annul_i      = 1'b0;

        repeat (3) @(posedge clk);
        #1;
        chk("rst_ready",  64'(bus.ready_o),    64'd0);
        chk("rst_result", bus.result_o,        64'd0);
        chk("rst_stall",  64'(bus.stallreq_o), 64'd0);
        bus.start_i = 1'b1;
        #1;
        chk("rst_stall_follows_start", 64'(bus.stallreq_o), 64'd1);
        bus.start_i = 1'b0;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        run_div(1'b0, 32'd100, 32'd7, "u100_7", 0);
        run_div(1'b1, 32'hFFFF_FFF9, 32'd2, "s_m7_2", 0);
        run_div(1'b1, 32'h8000_0000, 32'hFFFF_FFFF, "s_min_m1", 0);
        run_div(1'b0, 32'hFFFF_FFFF, 32'd1, "u_max_1", 0);
        run_div(1'b1, 32'd12345, 32'd0, "div_zero", 0);

        // Annul at iteration 10, then a fresh 9 / 3 must take the full latency.
        bus.signed_div_i = 1'b0;
        bus.opdata1_i    = 32'd50;
        bus.opdata2_i    = 32'd3;
        bus.start_i      = 1'b1;
        repeat (11) @(posedge clk);
        #1;
        bus.annul_i = 1'b1;
        #1;
        chk("annul_stall", 64'(bus.stallreq_o), 64'd0);
        @(posedge clk);
        #1;
        bus.annul_i = 1'b0;
        chk("annul_ready",  64'(bus.ready_o), 64'd0);
        chk("annul_result", bus.result_o,     64'd0);
        run_div(1'b0, 32'd9, 32'd3, "after_annul", 0);

        // Start together with annul in FREE must not launch.
        bus.opdata1_i = 32'd100;
        bus.opdata2_i = 32'd7;
        bus.start_i   = 1'b1;
        bus.annul_i   = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        chk("start_annul_ready", 64'(bus.ready_o), 64'd0);
        run_div(1'b0, 32'd100, 32'd7, "after_start_annul", 0);

        // Asynchronous reset mid-ON, between edges.
        bus.opdata1_i = 32'd1000;
        bus.opdata2_i = 32'd10;
        bus.start_i   = 1'b1;
        repeat (16) @(posedge clk);
        #3;
        rst_n = 1'b0;
        #1;
        chk("arst_on_ready",  64'(bus.ready_o),    64'd0);
        chk("arst_on_result", bus.result_o,        64'd0);
        chk("arst_on_stall",  64'(bus.stallreq_o), 64'd1);
        bus.start_i = 1'b0;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        chk("arst_idle_ready", 64'(bus.ready_o), 64'd0);
        run_div(1'b0, 32'd1000, 32'd10, "after_arst", 0);

        // Asynchronous reset while a result is being held in END.
        bus.signed_div_i = 1'b0;
        bus.opdata1_i    = 32'd77;
        bus.opdata2_i    = 32'd5;
        bus.start_i      = 1'b1;
        repeat (34) @(posedge clk);
        #1;
        chk("end_ready",  64'(bus.ready_o), 64'd1);
        chk("end_result", bus.result_o,     ref_div(1'b0, 32'd77, 32'd5));
        #3;
        rst_n = 1'b0;
        #1;
        chk("arst_end_ready",  64'(bus.ready_o), 64'd0);
        chk("arst_end_result", bus.result_o,     64'd0);
        bus.start_i = 1'b0;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        run_div(1'b1, 32'hFFFF_FF9C, 32'd7, "hold", 3);

        for (int i = 0; i < 24; i++) begin
            s   = 1'($urandom_range(0, 1));
            a   = $urandom;
            b   = $urandom;
            sel = int'($urandom_range(0, 7));
            if (sel == 0) b = 32'd0;
            if (sel == 1) b = $urandom_range(1, 15);
            if (sel == 2) begin
                a = 32'h8000_0000;
                b = 32'hFFFF_FFFF;
            end
            if (sel == 3) b = -$urandom_range(1, 15);
            run_div(s, a, b, $sformatf("rand%0d", i), int'($urandom_range(0, 1)));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
